// File: rtl/serial_defs.sv
// Shared serial line definitions: FSM state encoding and line levels.
// The matching receiver imports the same package.
package serial_defs;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/serial_tx_if.sv
// Producer-to-transmitter handshake: payload, valid and ready.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;

  modport master (output data_in, output valid, input ready);
  modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/baud_gen.sv
// Bit-period timer: BAUD_DIV-cycle down-counter. restart preloads the
// counter so the first tick lands BAUD_DIV cycles after restart drops.
module baud_gen #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic restart,
  output logic bit_tick
);
  localparam logic [7:0] RELOAD = 8'(BAUD_DIV - 1);

  logic [7:0] cnt;

  // Count down; reload on restart or on reaching zero, never wrap by overflow.
  always_ff @(posedge clk or posedge clear) begin
    if (clear)                         cnt <= '0;
    else if (restart || cnt == 8'd0)   cnt <= RELOAD;
    else                               cnt <= cnt - 8'd1;
  end

  assign bit_tick = (cnt == 8'd0);
endmodule

// File: rtl/serial_tx.sv
// UART-style serial transmitter: start bit, DATA_W bits LSB first,
// optional even parity, one stop bit. tx and ready are registered.
module serial_tx
  import serial_defs::*;
#(
  parameter int DATA_W    = 8,
  parameter int BAUD_DIV  = 4,
  parameter int PARITY_EN = 0
) (
  input  logic clk,
  input  logic clear,
  serial_tx_if.slave sif,
  output logic tx,
  output logic busy,
  output logic done
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [BW-1:0]     bitcnt;
  logic              tick;
  logic              accept;

  assign accept = sif.valid && sif.ready;
  assign busy   = (state != IDLE);

  // Timer held in restart while idle so START gets a full bit period.
  baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk      (clk),
    .clear    (clear),
    .restart  (state == IDLE),
    .bit_tick (tick)
  );

  // Frame sequencer. The shift register rotates rather than shifts, so
  // its XOR stays equal to the latched payload's parity throughout.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      tx        <= LINE_IDLE;
      done      <= 1'b0;
      sif.ready <= 1'b0;
      sreg      <= '0;
      bitcnt    <= '0;
    end else begin
      done      <= 1'b0;
      sif.ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= sif.data_in;
            tx    <= LINE_START;
            state <= START;
          end else begin
            sif.ready <= 1'b1;
            tx        <= LINE_IDLE;
          end
        end
        START: begin
          if (tick) begin
            state  <= DATA;
            tx     <= sreg[0];
            bitcnt <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bitcnt == LAST) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= ^sreg;
              end else begin
                state <= STOP;
                tx    <= LINE_STOP;
              end
            end else begin
              sreg   <= {sreg[0], sreg[DATA_W-1:1]};
              tx     <= sreg[1];
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= LINE_STOP;
          end
        end
        STOP: begin
          if (tick) begin
            state     <= IDLE;
            done      <= 1'b1;
            sif.ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= LINE_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// Directed bench: three transmitters (8/4/no parity, 8/4/parity, 8/2/no
// parity) share clk and clear; each frame is checked cycle by cycle.
module tb_serial_tx;
  logic clk = 1'b0;
  logic clear;
  logic tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
  int nrun = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  serial_tx_if #(.DATA_W(8)) sif0 ();
  serial_tx_if #(.DATA_W(8)) sif1 ();
  serial_tx_if #(.DATA_W(8)) sif2 ();

  serial_tx #(.DATA_W(8), .BAUD_DIV(4), .PARITY_EN(0)) dut0 (
    .clk(clk), .clear(clear), .sif(sif0), .tx(tx0), .busy(busy0), .done(done0));
  serial_tx #(.DATA_W(8), .BAUD_DIV(4), .PARITY_EN(1)) dut1 (
    .clk(clk), .clear(clear), .sif(sif1), .tx(tx1), .busy(busy1), .done(done1));
  serial_tx #(.DATA_W(8), .BAUD_DIV(2), .PARITY_EN(0)) dut2 (
    .clk(clk), .clear(clear), .sif(sif2), .tx(tx2), .busy(busy2), .done(done2));

  logic [2:0] tx_v, busy_v, done_v, ready_v;
  assign tx_v    = {tx2, tx1, tx0};
  assign busy_v  = {busy2, busy1, busy0};
  assign done_v  = {done2, done1, done0};
  assign ready_v = {sif2.ready, sif1.ready, sif0.ready};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nrun++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int d, input logic v, input logic [7:0] x);
    case (d)
      0: begin sif0.valid = v; sif0.data_in = x; end
      1: begin sif1.valid = v; sif1.data_in = x; end
      default: begin sif2.valid = v; sif2.data_in = x; end
    endcase
  endtask

  function automatic logic expbit(input logic [7:0] dd, input int i, input int pen);
    if (i == 0) return 1'b0;
    if (i <= 8) return dd[i-1];
    if (pen != 0 && i == 9) return ^dd;
    return 1'b1;
  endfunction

  // Caller has already raised valid; the acceptance edge is the next posedge.
  task automatic run_frame(input int d, input logic [7:0] dd, input int div, input int pen,
                           input logic nv, input logic [7:0] nd, input int poke, input int abrt);
    int total;
    logic saw_done, saw_low;
    total = (2 + 8 + pen) * div;
    @(posedge clk);
    @(negedge clk);
    set_in(d, nv, nd);
    for (int k = 0; k <= total; k++) begin
      if (k == abrt) begin
        #1 clear = 1'b1;
        #1;
        chk($sformatf("abort tx d%0d", d), 32'(tx_v[d]), 32'd1);
        chk($sformatf("abort busy d%0d", d), 32'(busy_v[d]), 32'd0);
        chk($sformatf("abort done d%0d", d), 32'(done_v[d]), 32'd0);
        chk($sformatf("abort ready d%0d", d), 32'(ready_v[d]), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        chk($sformatf("post-abort ready d%0d", d), 32'(ready_v[d]), 32'd1);
        saw_done = 1'b0;
        saw_low  = 1'b0;
        for (int j = 0; j < 12 * div; j++) begin
          @(negedge clk);
          if (done_v[d] !== 1'b0) saw_done = 1'b1;
          if (tx_v[d] !== 1'b1) saw_low = 1'b1;
        end
        chk($sformatf("post-abort no done d%0d", d), 32'(saw_done), 32'd0);
        chk($sformatf("post-abort tx idle d%0d", d), 32'(saw_low), 32'd0);
        return;
      end
      if (k == poke) set_in(d, 1'b1, 8'hFF);
      else if (k == poke + 1) set_in(d, nv, nd);
      if (k < total) begin
        chk($sformatf("tx d%0d data %0h cyc %0d", d, dd, k), 32'(tx_v[d]), 32'(expbit(dd, k / div, pen)));
        chk($sformatf("busy d%0d cyc %0d", d, k), 32'(busy_v[d]), 32'd1);
        chk($sformatf("done early d%0d cyc %0d", d, k), 32'(done_v[d]), 32'd0);
        @(negedge clk);
      end else begin
        chk($sformatf("done d%0d cyc %0d", d, k), 32'(done_v[d]), 32'd1);
        chk($sformatf("ready at done d%0d", d), 32'(ready_v[d]), 32'd1);
        chk($sformatf("busy at done d%0d", d), 32'(busy_v[d]), 32'd0);
        chk($sformatf("tx at done d%0d", d), 32'(tx_v[d]), 32'd1);
      end
    end
    if (!nv) begin
      @(negedge clk);
      chk($sformatf("done one-shot d%0d", d), 32'(done_v[d]), 32'd0);
      chk($sformatf("ready after done d%0d", d), 32'(ready_v[d]), 32'd1);
    end
  endtask

  initial begin
    logic bad;
    clear = 1'b1;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    set_in(2, 1'b0, 8'h00);
    #3;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset tx d%0d", d), 32'(tx_v[d]), 32'd1);
      chk($sformatf("reset busy d%0d", d), 32'(busy_v[d]), 32'd0);
      chk($sformatf("reset done d%0d", d), 32'(done_v[d]), 32'd0);
      chk($sformatf("reset ready d%0d", d), 32'(ready_v[d]), 32'd0);
    end
    #4 clear = 1'b0;
    @(negedge clk);
    chk("ready before first edge", 32'(ready_v[0]), 32'd0);
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("ready after release d%0d", d), 32'(ready_v[d]), 32'd1);

    // Basic frame; payload changes right after acceptance.
    set_in(0, 1'b1, 8'hA5);
    run_frame(0, 8'hA5, 4, 0, 1'b0, 8'h5A, -1, -1);

    // Parity frames: 07 has odd weight -> parity 1, 03 -> parity 0.
    set_in(1, 1'b1, 8'h07);
    run_frame(1, 8'h07, 4, 1, 1'b0, 8'h00, -1, -1);
    set_in(1, 1'b1, 8'h03);
    run_frame(1, 8'h03, 4, 1, 1'b0, 8'h00, -1, -1);

    // Back-to-back with valid held high.
    set_in(0, 1'b1, 8'h55);
    run_frame(0, 8'h55, 4, 0, 1'b1, 8'hAA, -1, -1);
    run_frame(0, 8'hAA, 4, 0, 1'b0, 8'h00, -1, -1);

    // Valid pulsed mid-DATA must be ignored.
    set_in(0, 1'b1, 8'h3C);
    run_frame(0, 8'h3C, 4, 0, 1'b0, 8'h00, 18, -1);
    bad = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad = 1'b1;
    end
    chk("no frame from ignored valid", 32'(bad), 32'd0);

    // Clear during data bit 3 (frame cycles 16..19), then a clean frame.
    set_in(0, 1'b1, 8'h5A);
    run_frame(0, 8'h5A, 4, 0, 1'b0, 8'h00, -1, 17);
    set_in(0, 1'b1, 8'h81);
    run_frame(0, 8'h81, 4, 0, 1'b0, 8'h00, -1, -1);

    // Shortest bit period: 18 low cycles then 2 high.
    set_in(2, 1'b1, 8'h00);
    run_frame(2, 8'h00, 2, 0, 1'b0, 8'h00, -1, -1);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end
endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DATA_W, default 8, meaning payload width in bits.
REQ-002 Parameter BAUD_DIV, default 4, meaning clk cycles per serial bit (legal range 2..255).
REQ-003 Parameter PARITY_EN, default 0, meaning 1 inserts an even-parity bit after the data bits.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 clear  input  1  reset, asynchronous, active-high.
REQ-006 data_in  input  DATA_W  parallel payload, sampled only on acceptance.
REQ-007 valid  input  1  producer offers data_in this cycle.
REQ-008 ready  output  1  block accepts a payload this cycle.
REQ-009 tx  output  1  serial line, registered, idle level 1.
REQ-010 busy  output  1  a frame is in progress.
REQ-011 done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 Acceptance occurs on a rising edge with valid=1 and ready=1; data_in is latched into a shift register at that edge.
REQ-013 ready shall be 1 only in state IDLE; valid while ready=0 is ignored, with no queuing.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-015 Transitions: IDLE->START on acceptance; START->DATA after BAUD_DIV cycles; DATA->PARITY (PARITY_EN=1) or DATA->STOP after DATA_W bits; PARITY->STOP after BAUD_DIV cycles; STOP->IDLE after BAUD_DIV cycles.
REQ-016 tx levels: START drives 0; DATA drives LSB first; PARITY drives the XOR of all latched data bits; STOP and IDLE drive 1.
REQ-017 Latency: tx falls to 0 on the first edge after acceptance; every bit lasts exactly BAUD_DIV cycles.
REQ-018 Frame length shall be (2 + DATA_W + PARITY_EN) * BAUD_DIV cycles from the first tx=0 cycle to the first IDLE cycle.
REQ-019 done shall be 1 for exactly the one cycle in which the state is first IDLE after STOP; ready is 1 in that same cycle.
REQ-020 Back-to-back: acceptance in the done cycle drives tx=0 on the next edge, giving no extra idle bit beyond STOP.
REQ-021 busy = (state != IDLE).
REQ-022 Changes on data_in after acceptance shall not affect the frame in flight.
REQ-023 A bit counter of ceil(log2(DATA_W+1)) bits and a baud counter of 8 bits shall wrap only by explicit reload, never by overflow.

Reset
REQ-024 clear=1 shall immediately, without waiting for clk, force state=IDLE, tx=1, busy=0, done=0, ready=0, and both counters and the shift register to 0.
REQ-025 ready shall become 1 on the first rising edge after clear deasserts.
REQ-026 clear asserted mid-frame shall abort the frame: tx returns to 1 at once, no done pulse is produced, and the partial frame is not resumed.

Structure
REQ-027 The shared package/include serial_defs shall hold the FSM state encoding (3 bits) and the idle/start/stop line-level constants, for reuse by the matching receiver.
REQ-028 The design shall use one sub-module, baud_gen, a BAUD_DIV down-counter with a synchronous restart input and a one-cycle bit_tick output, reset by clear.
REQ-029 tx shall be driven directly from a flop, with no combinational path from inputs to tx.

Verification (DATA_W=8, BAUD_DIV=4 unless stated)
REQ-030 clear=1 for 7 ns, then released; valid=1 with data_in=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles wide; done pulses at cycle 40 after tx first falls.
REQ-031 PARITY_EN=1, data_in=8'h07 -> parity bit 1, frame 44 cycles; data_in=8'h03 -> parity bit 0.
REQ-032 valid held at 1 with data_in=8'h55 then 8'hAA -> two frames with no gap; the second start bit begins on the edge after the done cycle.
REQ-033 valid pulsed during DATA with data_in=8'hFF -> ignored; the current frame is unchanged and no second frame is sent.
REQ-034 clear pulsed during bit 3 of the DATA state -> tx=1 asynchronously, busy=0, no done pulse; a new frame with 8'h81 afterwards is correct.
REQ-035 BAUD_DIV=2 with data_in=8'h00 -> 20-cycle frame: tx low for 18 cycles, then high for 2 cycles.
